// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: request/grant arbiter that shares one GMII transmit port
// between the ARP (0), UDP (1) and ICMP (2) transmit engines. A frame is
// never cut or interleaved and an inter-frame gap is enforced on the port.
// Optional build macro: ARP_PRIO_EN (ARP always wins, UDP/ICMP round-robin).
`timescale 1ns/1ps
module eth_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  src_req,
  output logic [2:0]  src_gnt,
  input  logic [2:0]  src_done,
  input  logic [2:0]  src_tx_en,
  input  logic [23:0] src_txd,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        busy,
  output logic [1:0]  cur_src,
  output logic        timeout_err
);

  localparam int CNT_MAX = (START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    txd_q, txd_d;

  logic          own_req_s, own_done_s, own_tx_en_s;
  logic [7:0]    own_txd_s;
  logic          win_vld_s, upd_rr_s;
  logic [1:0]    winner_s;

  // (v + 1) mod 3 for a source index
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // First requesting source scanning ptr, ptr+1, ptr+2 (mod 3); returns {valid, index}
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] r;
    r   = 3'b000;
    idx = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!r[2] && req[idx]) begin
        r = {1'b1, idx};
      end
      idx = inc_mod3(idx);
    end
    return r;
  endfunction

  // Select the owning source's request, done, tx_en and data; all others are ignored
  always_comb begin
    own_req_s   = 1'b0;
    own_done_s  = 1'b0;
    own_tx_en_s = 1'b0;
    own_txd_s   = 8'h00;
    case (cur_q)
      2'd0: begin
        own_req_s   = src_req[0];
        own_done_s  = src_done[0];
        own_tx_en_s = src_tx_en[0];
        own_txd_s   = src_txd[7:0];
      end
      2'd1: begin
        own_req_s   = src_req[1];
        own_done_s  = src_done[1];
        own_tx_en_s = src_tx_en[1];
        own_txd_s   = src_txd[15:8];
      end
      2'd2: begin
        own_req_s   = src_req[2];
        own_done_s  = src_done[2];
        own_tx_en_s = src_tx_en[2];
        own_txd_s   = src_txd[23:16];
      end
      default: begin
        own_req_s   = 1'b0;
        own_done_s  = 1'b0;
        own_tx_en_s = 1'b0;
        own_txd_s   = 8'h00;
      end
    endcase
  end

  // Pick the next winner from the pending requests
  always_comb begin
    logic [2:0] pick;
    pick = 3'b000;
`ifdef ARP_PRIO_EN
    if (src_req[0]) begin
      // ARP bypasses the rotation and leaves the pointer untouched
      pick     = 3'b100;
      upd_rr_s = 1'b0;
    end else begin
      pick     = rr_pick(src_req & 3'b110, rr_q);
      upd_rr_s = 1'b1;
    end
`else
    pick     = rr_pick(src_req, rr_q);
    upd_rr_s = 1'b1;
`endif
    win_vld_s = pick[2];
    winner_s  = pick[1:0];
  end

  // Next-state logic for the arbitration FSM
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = 3'b000;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld_s) begin
          state_d = GRANT;
          cur_d   = winner_s;
          gnt_d   = 3'b001 << winner_s;
          cnt_d   = '0;
          if (upd_rr_s) begin
            rr_d = inc_mod3(winner_s);
          end else begin
            rr_d = rr_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (own_done_s) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (own_tx_en_s) begin
          state_d = XFER;
        end else if (!own_req_s) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      XFER: begin
        if (own_done_s) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          state_d = XFER;
        end
      end
      GAP: begin
        // A zero-cycle gap still spends one cycle here
        if ((cnt_q + CW'(1)) >= CW'(IFG_CYCLES)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // GMII mux: forward the owner only while it holds the port, else drive idle
  always_comb begin
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    if (((state_q == GRANT) || (state_q == XFER)) && own_tx_en_s) begin
      tx_en_d = 1'b1;
      txd_d   = own_txd_s;
    end else begin
      tx_en_d = 1'b0;
      txd_d   = 8'h00;
    end
  end

  // FSM and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // GMII output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
    end else begin
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
    end
  end

  assign src_gnt     = gnt_q;
  assign gmii_tx_en  = tx_en_q;
  assign gmii_txd    = txd_q;
  assign busy        = busy_q;
  assign cur_src     = cur_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: stimulus pushes expected grants,
// bytes and timeout pulses into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  src_req = 3'b000;
  logic [2:0]  src_gnt;
  logic [2:0]  src_done = 3'b000;
  logic [2:0]  src_tx_en = 3'b000;
  logic [23:0] src_txd = 24'h000000;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy;
  logic [1:0]  cur_src;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  logic [2:0] exp_gnt[$];
  logic [7:0] exp_byte[$];
  int         exp_err[$];

  eth_tx_arbiter #(.IFG_CYCLES(12), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_gnt(src_gnt),
    .src_done(src_done), .src_tx_en(src_tx_en), .src_txd(src_txd),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .busy(busy),
    .cur_src(cur_src), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic int idx_of(input logic [2:0] oh);
    if (oh[0]) return 0;
    if (oh[1]) return 1;
    return 2;
  endfunction

  // Monitor: compare every grant, every transmitted byte and every timeout pulse
  initial begin
    logic [2:0] eg;
    logic [7:0] eb;
    int         dummy;
    int         low_run;
    bit         seen_frame;
    bit         prev_en;
    low_run = 0; seen_frame = 1'b0; prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_run = 0; seen_frame = 1'b0; prev_en = 1'b0;
      end else begin
        if (src_gnt != 3'b000) begin
          if (exp_gnt.size() == 0) begin
            check("gnt_unexpected", 1'b0, int'(src_gnt), 0);
          end else begin
            eg = exp_gnt.pop_front();
            check("gnt_order", src_gnt == eg, int'(src_gnt), int'(eg));
            check("cur_src", int'(cur_src) == idx_of(eg), int'(cur_src), idx_of(eg));
          end
        end
        if (gmii_tx_en) begin
          if (!prev_en && seen_frame)
            check("ifg_min", low_run >= 12, low_run, 12);
          if (exp_byte.size() == 0) begin
            check("byte_unexpected", 1'b0, int'(gmii_txd), 0);
          end else begin
            eb = exp_byte.pop_front();
            check("gmii_txd", gmii_txd == eb, int'(gmii_txd), int'(eb));
          end
          seen_frame = 1'b1;
          low_run = 0;
        end else begin
          low_run++;
        end
        prev_en = gmii_tx_en;
        if (timeout_err) begin
          if (exp_err.size() == 0) check("err_unexpected", 1'b0, 1, 0);
          else dummy = exp_err.pop_front();
        end
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    src_req = 3'b000; src_done = 3'b000; src_tx_en = 3'b000; src_txd = 24'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Wait (bounded) until source s sees its grant at a negedge sample
  task automatic wait_gnt(input int s);
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (src_gnt[s]) return;
    end
    check("gnt_timeout", 1'b0, 0, s);
  endtask

  // Source s sends n bytes starting at base, then pulses done and sets src_req
  task automatic drive_frame(input int s, input int n, input logic [7:0] base,
                             input logic [2:0] req_after);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      src_tx_en[s] = 1'b1;
      src_txd[8*s +: 8] = base + 8'(i);
      exp_byte.push_back(base + 8'(i));
    end
    @(posedge clk); #1;
    src_tx_en[s] = 1'b0;
    src_txd[8*s +: 8] = 8'h00;
    src_done[s] = 1'b1;
    src_req = req_after;
    @(posedge clk); #1;
    src_done[s] = 1'b0;
  endtask

  initial begin
    int order[4];
    logic [7:0] bases[4];
`ifdef ARP_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0};
`endif
    bases = '{8'h10, 8'h20, 8'h30, 8'h18};

    // Reset state
    #3;
    check("rst_busy", busy == 1'b0, int'(busy), 0);
    check("rst_tx_en", gmii_tx_en == 1'b0, int'(gmii_tx_en), 0);
    check("rst_txd", gmii_txd == 8'h00, int'(gmii_txd), 0);
    check("rst_gnt", src_gnt == 3'b000, int'(src_gnt), 0);
    check("rst_cur", cur_src == 2'd0, int'(cur_src), 0);
    check("rst_err", timeout_err == 1'b0, int'(timeout_err), 0);
    reset_dut();

    // Test 1: UDP 10-byte frame, grant latency and gap length
    @(posedge clk); #1;
    exp_gnt.push_back(3'b010);
    src_req = 3'b010;
    @(negedge clk);
    check("t1_gnt_early", src_gnt == 3'b000, int'(src_gnt), 0);
    @(negedge clk);
    check("t1_gnt_latency", src_gnt == 3'b010, int'(src_gnt), 2);
    drive_frame(1, 10, 8'h00, 3'b000);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      check("t1_busy_gap", busy == (k < 12), int'(busy), int'(k < 12));
    end

    // Test 2: all three request continuously, 4-byte frames
    reset_dut();
    for (int i = 0; i < 4; i++) exp_gnt.push_back(3'b001 << order[i]);
    src_req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(order[i]);
      drive_frame(order[i], 4, bases[i], (i == 3) ? 3'b000 : 3'b111);
    end

    // Test 3: ICMP frame in progress, ARP and UDP request during it
    repeat (20) @(posedge clk); #1;
    exp_gnt.push_back(3'b100);
    exp_gnt.push_back(3'b001);
    exp_gnt.push_back(3'b010);
    src_req = 3'b100;
    wait_gnt(2);
    src_req = 3'b111;
    drive_frame(2, 5, 8'h40, 3'b011);
    wait_gnt(0);
    drive_frame(0, 3, 8'h48, 3'b010);
    wait_gnt(1);
    drive_frame(1, 3, 8'h4C, 3'b000);

    // Test 4: ICMP never starts; timeout, then pending UDP is served
    repeat (20) @(posedge clk); #1;
    exp_gnt.push_back(3'b100);
    exp_gnt.push_back(3'b010);
    exp_err.push_back(1);
    src_req = 3'b100;
    wait_gnt(2);
    src_req = 3'b110;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("t4_timeout_err", timeout_err == (k == 16), int'(timeout_err), int'(k == 16));
    end
    src_req = 3'b010;
    wait_gnt(1);
    drive_frame(1, 4, 8'h50, 3'b000);

    // Test 5: ARP drives 0xAA while UDP owns the port
    repeat (20) @(posedge clk); #1;
    src_tx_en[0] = 1'b1;
    src_txd[7:0] = 8'hAA;
    exp_gnt.push_back(3'b010);
    src_req = 3'b010;
    wait_gnt(1);
    drive_frame(1, 6, 8'h60, 3'b000);
    src_tx_en[0] = 1'b0;
    src_txd[7:0] = 8'h00;

    // Test 6: reset in the middle of a frame
    repeat (20) @(posedge clk); #1;
    exp_gnt.push_back(3'b010);
    src_req = 3'b010;
    wait_gnt(1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      src_tx_en[1] = 1'b1;
      src_txd[15:8] = 8'h90 + 8'(i);
      exp_byte.push_back(8'h90 + 8'(i));
    end
    @(posedge clk); #1;
    src_txd[15:8] = 8'h94;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_en", gmii_tx_en == 1'b0, int'(gmii_tx_en), 0);
    check("t6_rst_busy", busy == 1'b0, int'(busy), 0);
    check("t6_rst_gnt", src_gnt == 3'b000, int'(src_gnt), 0);
    reset_dut();
    exp_gnt.push_back(3'b010);
    src_req = 3'b110;
    wait_gnt(1);
    drive_frame(1, 2, 8'h70, 3'b000);

    repeat (20) @(posedge clk);
    check("end_gnt_queue", exp_gnt.size() == 0, exp_gnt.size(), 0);
    check("end_byte_queue", exp_byte.size() == 0, exp_byte.size(), 0);
    check("end_err_queue", exp_err.size() == 0, exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
